// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: source tags, transfer size codes,
// arbiter FSM states and the default outstanding-transaction depth.
package cpu_bus_arbiter_pkg;

  localparam logic       SRC_INST = 1'b0;
  localparam logic       SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;

  localparam int         ARB_OUTSTANDING = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cpu_bus_arbiter_order_fifo.sv
// Order FIFO of 1-bit source tags; records which CPU port issued each accepted
// memory request so in-order responses can be routed back.
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full blocks push even when a pop happens in the same cycle (no bypass).
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == C_FULL);
  assign empty  = (r_count == {CW{1'b0}});
  assign dout   = r_mem[r_rptr];

  // Storage, pointers (wrap naturally at a power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= {DEPTH{1'b0}};
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + PW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Merges the CPU instruction and data sram-like ports onto one in-order memory bus.
// Optional macro CPU_ARB_RR_EN: round-robin between ports instead of data-first priority.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = ARB_OUTSTANDING,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_unexp_rsp
);

  arb_state_t r_state;
  logic       r_sel_hold;
  logic       r_err;
  logic       w_sel;
  logic       w_sel_req;
  logic       w_mem_req;
  logic       w_push;
  logic       w_pop;
  logic       w_head;
  logic       w_full;
  logic       w_empty;
`ifdef CPU_ARB_RR_EN
  logic       r_last;
`endif

  // Port selection: latched while a request waits for grant, otherwise arbitrated
  always_comb begin
    if (r_state == ARB_HOLD) begin
      w_sel = r_sel_hold;
    end else if (inst_req && data_req) begin
`ifdef CPU_ARB_RR_EN
      w_sel = ~r_last;
`else
      w_sel = SRC_DATA;
`endif
    end else if (data_req) begin
      w_sel = SRC_DATA;
    end else begin
      w_sel = SRC_INST;
    end
  end

  // Memory request fields follow the selected port
  always_comb begin
    if (w_sel == SRC_DATA) begin
      w_sel_req = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      w_sel_req = inst_req;
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Handshakes are gated by reset so they drop the moment reset asserts.
  assign w_mem_req     = w_sel_req && !w_full && !reset;
  assign w_push        = w_mem_req && mem_gnt;
  assign w_pop         = mem_rvalid && !w_empty && !reset;
  assign mem_req       = w_mem_req;
  assign inst_addr_ok  = w_push && (w_sel == SRC_INST);
  assign data_addr_ok  = w_push && (w_sel == SRC_DATA);
  assign inst_data_ok  = w_pop && (w_head == SRC_INST);
  assign data_data_ok  = w_pop && (w_head == SRC_DATA);
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;
  assign err_unexp_rsp = r_err;

  arb_order_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_sel),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Arbiter FSM: hold the selection stable while the bus withholds grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_sel_hold <= SRC_INST;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_mem_req && !mem_gnt) begin
            r_state    <= ARB_HOLD;
            r_sel_hold <= w_sel;
          end else begin
            r_state    <= ARB_IDLE;
            r_sel_hold <= r_sel_hold;
          end
        end
        ARB_HOLD: begin
          if (w_push) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_HOLD;
          end
        end
        default: begin
          r_state    <= ARB_IDLE;
          r_sel_hold <= SRC_INST;
        end
      endcase
    end
  end

  // Sticky flag for a response that has no outstanding transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (mem_rvalid && w_empty) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

`ifdef CPU_ARB_RR_EN
  // Last-winner register for round-robin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= SRC_INST;
    end else if (w_push) begin
      r_last <= w_sel;
    end else begin
      r_last <= r_last;
    end
  end
`endif

endmodule
